// File: rtl/game_state_ctrl.sv
// Game flow controller: debounced start/pause button, START/PLAY/PAUSE/GAME_OVER FSM,
// wave counter and final-score latch. Define GAMEOVER_AUTO_EXIT_EN for a timed GAME_OVER exit.
module game_state_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int GAMEOVER_CYCLES = 81000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  buttons,
  input  logic [2:0]  game_status,
  input  logic [13:0] score,
  output logic [2:0]  game_state,
  output logic        start_pulse,
  output logic [7:0]  wave,
  output logic [13:0] last_score
);

  typedef enum logic [2:0] {
    S_START = 3'b000,
    S_PLAY  = 3'b001,
    S_PAUSE = 3'b010,
    S_OVER  = 3'b011
  } state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  state_t         state;
  logic [1:0]     sync;
  logic           db_level;
  logic [DBW-1:0] db_cnt;
  logic           press;
  logic           gs2_q;
  logic           timeout;
  logic           unused_in;

  assign unused_in  = ^{buttons[4:2], buttons[0], GAMEOVER_CYCLES[0]};
  assign game_state = state;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync     <= 2'b00;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync  <= {sync[0], buttons[1]};
      press <= 1'b0;
      if (sync[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt   <= '0;
        db_level <= sync[1];
        press    <= sync[1];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef GAMEOVER_AUTO_EXIT_EN
  localparam int TW = $clog2(GAMEOVER_CYCLES + 1);
  logic [TW-1:0] go_timer;

  assign timeout = (go_timer == TW'(GAMEOVER_CYCLES - 1));

  // Held at zero outside GAME_OVER, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n || state != S_OVER) go_timer <= '0;
    else                           go_timer <= go_timer + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_START;
      start_pulse <= 1'b0;
      wave        <= 8'd0;
      last_score  <= 14'd0;
      gs2_q       <= 1'b0;
    end else begin
      gs2_q       <= game_status[2];
      start_pulse <= 1'b0;
      unique case (state)
        S_START: if (press) begin
          state       <= S_PLAY;
          start_pulse <= 1'b1;
          wave        <= 8'd1;
        end
        // Collision wins over both the button and a wave-clear edge.
        S_PLAY: if (|game_status[1:0]) begin
          state      <= S_OVER;
          last_score <= score;
        end else begin
          if (press) state <= S_PAUSE;
          if (game_status[2] && !gs2_q && wave != 8'hFF) wave <= wave + 8'd1;
        end
        S_PAUSE: if (press) state <= S_PLAY;
        S_OVER:  if (press || timeout) state <= S_START;
        default: state <= S_START;
      endcase
    end
  end

endmodule
